fb_write_arbiter: RTL and testbench

- Sole owner of the frame-buffer write port (`fb_we`, `fb_addr`, `fb_data`), which connects to frameRAM's write side.
- Shares that port between two bike trail writers (blue = bike 0, red = bike 1) and an internal clear engine that fills the screen with the background colour at round start.
- Converts (x, y) to a linear pixel address and rejects off-screen writes.
- The display read path is unaffected.

---
 rtl/fb_write_arbiter_pkg.sv | 23 ++
 rtl/fb_write_arbiter_addr_calc.sv | 22 ++
 rtl/fb_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_fb_write_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// Shared frame-buffer constants and types for the trail writers and the write-port arbiter.
package tron_fb_pkg;

  localparam int unsigned H_RES     = 640;
  localparam int unsigned V_RES     = 480;
  localparam int unsigned FB_PIXELS = H_RES * V_RES;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned COLOR_W   = 4;

  typedef enum logic [3:0] {
    COLOR_BG    = 4'h0,
    COLOR_BLUE  = 4'h1,
    COLOR_RED   = 4'h2,
    COLOR_WALL  = 4'h3,
    COLOR_CRASH = 4'hF
  } color_e;

  typedef enum logic {
    IDLE,
    CLEAR
  } fbw_state_e;

endpackage

// File: rtl/fb_write_arbiter_addr_calc.sv
// Pixel (x, y) to linear frame-buffer address, with an on-screen flag.
module fb_addr_calc #(
  parameter int unsigned H_RES  = tron_fb_pkg::H_RES,
  parameter int unsigned V_RES  = tron_fb_pkg::V_RES,
  parameter int unsigned ADDR_W = tron_fb_pkg::ADDR_W
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  logic [ADDR_W-1:0] y_w;

  // y*640 as two shifts; the line length is fixed at 640 by this decomposition
  always_comb begin
    y_w      = ADDR_W'(y);
    addr     = (y_w << 9) + (y_w << 7) + ADDR_W'(x);
    in_range = (32'(x) < H_RES) && (32'(y) < V_RES);
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Owns the frame-buffer write port: round-robin between two bike writers, plus a full-screen clear sweep.
module fb_write_arbiter
  import tron_fb_pkg::*;
#(
  parameter int unsigned        H_RES    = tron_fb_pkg::H_RES,
  parameter int unsigned        V_RES    = tron_fb_pkg::V_RES,
  parameter int unsigned        ADDR_W   = tron_fb_pkg::ADDR_W,
  parameter int unsigned        COLOR_W  = tron_fb_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(COLOR_BG)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
  input  logic               b0_req,
  input  logic [9:0]         b0_x,
  input  logic [9:0]         b0_y,
  input  logic [COLOR_W-1:0] b0_color,
  output logic               b0_ack,
  input  logic               b1_req,
  input  logic [9:0]         b1_x,
  input  logic [9:0]         b1_y,
  input  logic [COLOR_W-1:0] b1_color,
  output logic               b1_ack,
  output logic               oob_err,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data
);

  localparam logic [ADDR_W-1:0] PIXELS = ADDR_W'(H_RES * V_RES);

  fbw_state_e        state_q, state_n;
  logic [ADDR_W-1:0] cnt_q, cnt_n;
  logic              ptr_q, ptr_n;

  logic               elig0, elig1, grant_any, grant_sel;
  logic [9:0]         sel_x, sel_y;
  logic [COLOR_W-1:0] sel_color;
  logic [ADDR_W-1:0]  calc_addr;
  logic               calc_in_range;

  logic               b0_ack_n, b1_ack_n, oob_n, we_n, busy_n, done_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [COLOR_W-1:0] data_n;

  // A bike whose ack is showing has not yet updated its request, so it is masked
  always_comb begin
    elig0     = b0_req && !b0_ack;
    elig1     = b1_req && !b1_ack;
    grant_any = elig0 || elig1;
    grant_sel = (elig0 && elig1) ? ptr_q : elig1;
    sel_x     = grant_sel ? b1_x     : b0_x;
    sel_y     = grant_sel ? b1_y     : b0_y;
    sel_color = grant_sel ? b1_color : b0_color;
  end

  fb_addr_calc #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_addr_calc (
    .x       (sel_x),
    .y       (sel_y),
    .addr    (calc_addr),
    .in_range(calc_in_range)
  );

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    ptr_n    = ptr_q;
    b0_ack_n = 1'b0;
    b1_ack_n = 1'b0;
    oob_n    = 1'b0;
    we_n     = 1'b0;
    addr_n   = fb_addr;
    data_n   = fb_data;
    busy_n   = clear_busy;
    done_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_n = CLEAR;
          busy_n  = 1'b1;
          cnt_n   = '0;
        end else if (grant_any) begin
          ptr_n    = ~grant_sel;
          b0_ack_n = ~grant_sel;
          b1_ack_n = grant_sel;
          if (calc_in_range) begin
            we_n   = 1'b1;
            addr_n = calc_addr;
            data_n = sel_color;
          end else begin
            oob_n = 1'b1;
          end
        end
      end
      CLEAR: begin
        // The counter runs one past the last pixel so the done pulse lands a cycle after the final write
        if (cnt_q == PIXELS) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          we_n   = 1'b1;
          addr_n = cnt_q;
          data_n = BG_COLOR;
          cnt_n  = cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      b0_ack     <= 1'b0;
      b1_ack     <= 1'b0;
      oob_err    <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      ptr_q      <= ptr_n;
      b0_ack     <= b0_ack_n;
      b1_ack     <= b1_ack_n;
      oob_err    <= oob_n;
      fb_we      <= we_n;
      fb_addr    <= addr_n;
      fb_data    <= data_n;
      clear_busy <= busy_n;
      clear_done <= done_n;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter; V_RES is shrunk so a full clear sweep stays short.
module tb_fb_write_arbiter;

  localparam int unsigned H  = 640;
  localparam int unsigned V  = 32;
  localparam int unsigned AW = 19;
  localparam int unsigned CW = 4;
  localparam int unsigned PIX = H * V;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_start = 1'b0;
  logic          clear_busy, clear_done;
  logic          b0_req = 1'b0, b1_req = 1'b0;
  logic [9:0]    b0_x = '0, b0_y = '0, b1_x = '0, b1_y = '0;
  logic [CW-1:0] b0_color = '0, b1_color = '0;
  logic          b0_ack, b1_ack, oob_err, fb_we;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] fb_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .H_RES   (H),
    .V_RES   (V),
    .ADDR_W  (AW),
    .COLOR_W (CW),
    .BG_COLOR(4'h0)
  ) dut (
    .Clk        (clk),
    .Reset      (rst),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .b0_req     (b0_req),
    .b0_x       (b0_x),
    .b0_y       (b0_y),
    .b0_color   (b0_color),
    .b0_ack     (b0_ack),
    .b1_req     (b1_req),
    .b1_x       (b1_x),
    .b1_y       (b1_y),
    .b1_color   (b1_color),
    .b1_ack     (b1_ack),
    .oob_err    (oob_err),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  function automatic logic [11:0] pack_out();
    return {b0_ack, b1_ack, oob_err, fb_we, clear_busy, clear_done, fb_addr[AW-1:AW-2], fb_data};
  endfunction

  task automatic test_reset;
    int bad;
    do_reset(3);
    checks++;
    if (pack_out() !== 12'h000 || fb_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got flags=%h addr=%0d required flags=0 addr=0", pack_out(), fb_addr);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (fb_we !== 1'b0 || b0_ack !== 1'b0 || b1_ack !== 1'b0 || clear_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_single_bike;
    do_reset(1);
    b0_x = 10'd5; b0_y = 10'd2; b0_color = 4'h3; b0_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (i % 2 == 0) begin
        if (b0_ack !== 1'b1 || fb_we !== 1'b1 || fb_addr !== 19'd1285 || fb_data !== 4'h3) begin
          errors++;
          $display("FAIL single_write[%0d]: got ack=%b we=%b addr=%0d data=%0d required ack=1 we=1 addr=1285 data=3",
                   i, b0_ack, fb_we, fb_addr, fb_data);
        end
      end else begin
        if (b0_ack !== 1'b0 || fb_we !== 1'b0) begin
          errors++;
          $display("FAIL single_gap[%0d]: got ack=%b we=%b required ack=0 we=0", i, b0_ack, fb_we);
        end
      end
    end
    b0_req = 1'b0;
    step();
  endtask

  task automatic test_both_bikes;
    logic [AW-1:0] exp_addr;
    do_reset(1);
    b0_x = 10'd0;   b0_y = 10'd0;     b0_color = 4'h1;
    b1_x = 10'd639; b1_y = 10'(V - 1); b1_color = 4'h2;
    b0_req = 1'b1; b1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_addr = (i % 2 == 0) ? 19'd0 : 19'(PIX - 1);
      checks++;
      if (b0_ack !== (i % 2 == 0) || b1_ack !== (i % 2 == 1) || fb_we !== 1'b1 ||
          fb_addr !== exp_addr || fb_data !== ((i % 2 == 0) ? 4'h1 : 4'h2)) begin
        errors++;
        $display("FAIL alternate[%0d]: got a0=%b a1=%b we=%b addr=%0d data=%0d required a0=%0d a1=%0d we=1 addr=%0d",
                 i, b0_ack, b1_ack, fb_we, fb_addr, fb_data, (i % 2 == 0), (i % 2 == 1), exp_addr);
      end
    end
    b0_req = 1'b0; b1_req = 1'b0;
    step();
    checks++;
    if (fb_we !== 1'b0 || b0_ack !== 1'b0 || b1_ack !== 1'b0) begin
      errors++;
      $display("FAIL both_release: got we=%b a0=%b a1=%b required 0 0 0", fb_we, b0_ack, b1_ack);
    end
  endtask

  task automatic test_oob;
    do_reset(1);
    b1_x = 10'd640; b1_y = 10'd10; b1_color = 4'h5; b1_req = 1'b1;
    step();
    b1_req = 1'b0;
    checks++;
    if (b1_ack !== 1'b1 || oob_err !== 1'b1 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL oob_x: got ack=%b oob=%b we=%b required ack=1 oob=1 we=0", b1_ack, oob_err, fb_we);
    end
    step();
    checks++;
    if (oob_err !== 1'b0 || b1_ack !== 1'b0) begin
      errors++;
      $display("FAIL oob_pulse: got oob=%b ack=%b required 0 0", oob_err, b1_ack);
    end
    b0_x = 10'd0; b0_y = 10'(V); b0_color = 4'h4; b0_req = 1'b1;
    step();
    b0_req = 1'b0;
    checks++;
    if (b0_ack !== 1'b1 || oob_err !== 1'b1 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL oob_y: got ack=%b oob=%b we=%b required ack=1 oob=1 we=0", b0_ack, oob_err, fb_we);
    end
    step();
  endtask

  task automatic test_clear;
    int bad;
    int first_bad;
    do_reset(1);
    b0_x = 10'd5; b0_y = 10'd2; b0_color = 4'h3; b0_req = 1'b1;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    checks++;
    if (clear_busy !== 1'b1 || b0_ack !== 1'b0 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL clear_enter: got busy=%b ack=%b we=%b required busy=1 ack=0 we=0", clear_busy, b0_ack, fb_we);
    end
    bad = 0;
    first_bad = -1;
    for (int k = 0; k < PIX; k++) begin
      step();
      if (fb_we !== 1'b1 || fb_addr !== AW'(k) || fb_data !== 4'h0 || b0_ack !== 1'b0 ||
          clear_busy !== 1'b1 || clear_done !== 1'b0) begin
        if (first_bad < 0) first_bad = k;
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL clear_sweep: got %0d bad cycles (first at %0d) required 0", bad, first_bad);
    end
    step();
    checks++;
    if (clear_done !== 1'b1 || clear_busy !== 1'b0 || fb_we !== 1'b0 || b0_ack !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: got done=%b busy=%b we=%b ack=%b required done=1 busy=0 we=0 ack=0",
               clear_done, clear_busy, fb_we, b0_ack);
    end
    step();
    b0_req = 1'b0;
    checks++;
    if (clear_done !== 1'b0 || b0_ack !== 1'b1 || fb_we !== 1'b1 || fb_addr !== 19'd1285) begin
      errors++;
      $display("FAIL clear_then_bike: got done=%b ack=%b we=%b addr=%0d required done=0 ack=1 we=1 addr=1285",
               clear_done, b0_ack, fb_we, fb_addr);
    end
    step();
  endtask

  task automatic test_reset_mid_clear;
    int bad;
    do_reset(1);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int k = 0; k <= 1000; k++) step();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 19'd1000) begin
      errors++;
      $display("FAIL mid_clear_addr: got we=%b addr=%0d required we=1 addr=1000", fb_we, fb_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (clear_busy !== 1'b0 || fb_we !== 1'b0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_reset: got busy=%b we=%b done=%b required 0 0 0", clear_busy, fb_we, clear_done);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clear_done !== 1'b0 || fb_we !== 1'b0 || clear_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL no_resume: got %0d active cycles required 0", bad);
    end
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    step();
    checks++;
    if (clear_busy !== 1'b1 || fb_we !== 1'b1 || fb_addr !== 19'd0) begin
      errors++;
      $display("FAIL restart_addr0: got busy=%b we=%b addr=%0d required busy=1 we=1 addr=0", clear_busy, fb_we, fb_addr);
    end
    step();
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 19'd1) begin
      errors++;
      $display("FAIL restart_addr1: got we=%b addr=%0d required we=1 addr=1", fb_we, fb_addr);
    end
    do_reset(1);
  endtask

  initial begin
    #1;
    test_reset();
    test_single_bike();
    test_both_bikes();
    test_oob();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
